// File: rtl/t_ff_to_sr_ff.sv
// SR register built from T-type storage: each bit keeps its state only through
// q <= q ^ t, with per-bit S=R=1 detection, a sticky error flag and a saturating counter.
module t_ff_to_sr_ff #(
  parameter int WIDTH       = 4,
  parameter int SR11_POLICY = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] t_out,
  output logic [WIDTH-1:0] illegal,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] POLICY_HOLD  = 2'd0;
  localparam logic [1:0] POLICY_SET   = 2'd1;
  localparam logic [1:0] POLICY_RESET = 2'd2;

  // Any value other than set- or reset-dominant falls back to hold.
  localparam logic [1:0] POLICY_EFF = (SR11_POLICY == 1) ? POLICY_SET   :
                                      (SR11_POLICY == 2) ? POLICY_RESET :
                                                           POLICY_HOLD;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] illegal_q, illegal_d;
  logic [WIDTH-1:0] t_cmd;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             illegal_cycle;

  // Toggle command: a bit toggles exactly when its requested next value differs from q.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    t_cmd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (en) begin
        case ({s[i], r[i]})
          2'b10:   t_cmd[i] = ~q_q[i];
          2'b01:   t_cmd[i] = q_q[i];
          2'b11: begin
            if (POLICY_EFF == POLICY_SET) begin
              t_cmd[i] = ~q_q[i];
            end else if (POLICY_EFF == POLICY_RESET) begin
              t_cmd[i] = q_q[i];
            end else begin
              t_cmd[i] = 1'b0;
            end
          end
          default: t_cmd[i] = 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    q_d           = q_q ^ t_cmd;
    illegal_d     = {WIDTH{en}} & s & r;
    illegal_cycle = |illegal_d;

    // A fresh illegal event outranks a simultaneous clear.
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (illegal_cycle) begin
      err_sticky_d = 1'b1;
      if (clr_err) begin
        err_cnt_d = CNT_ONE;
      end else if (err_cnt_q != CNT_MAX) begin
        err_cnt_d = err_cnt_q + CNT_ONE;
      end
    end else if (clr_err) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      q_q          <= '0;
      illegal_q    <= '0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      q_q          <= q_d;
      illegal_q    <= illegal_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign q          = q_q;
  assign qbar       = ~q_q;
  assign t_out      = t_cmd;
  assign illegal    = illegal_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;

endmodule
